traffic_light_driver: RTL and testbench
=======================================

// Module: traffic_light_driver
// PURPOSE
//  Downstream of traffic_system_top: turns its per-lane grants allow_0..allow_3 into lamp drives.
//  Inserts a timed yellow phase when a grant drops and a timed all-red clearance before any green.
//  Guarantees at most one non-red lane at any time. Single FSM, Moore outputs, registered.
// PARAMETERS
//  YELLOW_CYCLES  3  yellow duration in clk cycles (>=1)
//  ALLRED_CYCLES  2  minimum all-red clearance in clk cycles (>=1)
//  CNT_W          8  phase timer width; both durations must fit in CNT_W bits
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  allow_0..3   in   1  per-lane grant from traffic_system_top
//  lamp_red     out  4  bit i = red lamp of lane i
//  lamp_yellow  out  4  bit i = yellow lamp of lane i
//  lamp_green   out  4  bit i = green lamp of lane i
//  phase        out  2  current phase (PH_ALL_RED/PH_GREEN/PH_YELLOW)
//  owner        out  2  lane index currently green/yellow; 0 in PH_ALL_RED
// BEHAVIOUR
//  - Reset (sync, any state): phase=PH_ALL_RED, owner=0, timer=ALLRED_CYCLES-1,
//    lamp_red=4'b1111, lamp_yellow=0, lamp_green=0 on the edge rst is sampled high.
//  - Timer: loaded with duration-1 on phase entry, decrements each cycle, saturates at 0; expired = (timer==0).
//  - PH_ALL_RED: wait until expired; then on first cycle with a request, go PH_GREEN at next edge,
//    owner = requesting lane (several requests: lowest index wins). No request: stay, timer held at 0.
//  - PH_GREEN: stay while allow[owner]=1; allow[owner]=0 -> PH_YELLOW next edge, timer=YELLOW_CYCLES-1.
//    Requests from other lanes are ignored while owner holds.
//  - PH_YELLOW: lasts exactly YELLOW_CYCLES cycles; allow[owner] re-asserting does NOT abort it.
//    On expiry -> PH_ALL_RED, timer=ALLRED_CYCLES-1, owner=0.
//  - Lamps: owner lane shows exactly one of green/yellow per phase; all other lanes red.
//    Invariant: per lane exactly one lamp lit; at most one lane non-red.
//  - Latency: grant-to-green min 1 cycle once clearance expired; green is never shown within
//    ALLRED_CYCLES cycles after reset release or after yellow ends.
// CONFIGURATION
//  LIGHT_DRIVER_FAULT_EN defined: extra port fault (out, 1, reset 0, sticky until rst).
//    fault sets when >1 allow is high in PH_ALL_RED, or any non-owner allow is high in PH_GREEN.
//    Fault in PH_GREEN forces PH_YELLOW next edge. While fault=1, FSM never leaves PH_ALL_RED.
//  Not defined: no fault port; lowest-index priority only; conflicting grants otherwise ignored.
// STRUCTURE
//  traffic_pkg: phase_e enum {PH_ALL_RED=2'd0, PH_GREEN=2'd1, PH_YELLOW=2'd2}, NUM_LANES=4,
//    lane index typedef lane_t (2 bits). Shared with traffic_system_top bench.
//  Sub-module phase_timer: CNT_W down-counter with load/value/expired; instantiated once.
// TESTING (YELLOW_CYCLES=3, ALLRED_CYCLES=2)
//  1 rst=1 for 2 cycles, all allow=0 -> lamp_red=4'b1111, yellow=0, green=0, phase=0, owner=0.
//  2 release rst with allow_2=1 held -> red for 2 cycles, lamp_green=4'b0100 from 2nd edge, owner=2.
//  3 drop allow_2 -> next edge lamp_yellow=4'b0100 for exactly 3 cycles, then 4'b1111 red for
//    2 cycles; allow_0=1 then -> lamp_green=4'b0001.
//  4 re-raise allow_0 during its yellow -> yellow still completes 3 cycles, then >=2 cycles all-red.
//  5 allow_1=allow_3=1 in PH_ALL_RED -> without macro lamp_green=4'b0010; with
//    LIGHT_DRIVER_FAULT_EN fault=1 and lamp_red stays 4'b1111 until rst.
//  6 rst=1 mid-yellow -> next edge all outputs at reset values; check invariant every cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lane/phase types for the traffic light driver and the traffic_system_top bench.
package traffic_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_e;

    // Lowest-index requesting lane; 0 when nothing requests.
    function automatic lane_t lowest_lane(input logic [NUM_LANES-1:0] req);
        lane_t r;
        r = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                r = lane_t'(i);
            end
        end
        return r;
    endfunction

    function automatic logic multi_hot(input logic [NUM_LANES-1:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/traffic_light_driver_timer.sv
// Phase timer: loadable down-counter that saturates at zero; expired while it reads zero.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign value_o   = cnt_q;
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_driver.sv
// Turns per-lane grants into lamp drives with timed yellow and all-red clearance phases.
// Optional LIGHT_DRIVER_FAULT_EN adds a sticky conflicting-grant fault output.
module traffic_light_driver
    import traffic_pkg::*;
#(
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       allow_0,
    input  logic       allow_1,
    input  logic       allow_2,
    input  logic       allow_3,
    output logic [3:0] lamp_red,
    output logic [3:0] lamp_yellow,
    output logic [3:0] lamp_green,
    output logic [1:0] phase,
`ifdef LIGHT_DRIVER_FAULT_EN
    output logic [1:0] owner,
    output logic       fault
`else
    output logic [1:0] owner
`endif
);

    localparam logic [CNT_W-1:0] YEL_LOAD    = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);

    logic [NUM_LANES-1:0] allow;
    phase_e               phase_q, phase_d;
    lane_t                owner_q, owner_d;
    logic [3:0]           red_q, red_d, yel_q, yel_d, grn_q, grn_d;
    logic [3:0]           owner_mask_d;
    logic                 timer_load;
    logic [CNT_W-1:0]     timer_val;
    logic [CNT_W-1:0]     timer_value;
    logic                 expired;
    logic                 block;
    logic                 force_yellow;

    assign allow = {allow_3, allow_2, allow_1, allow_0};

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .load_i    (timer_load | rst),
        .load_val_i(rst ? ALLRED_LOAD : timer_val),
        .value_o   (timer_value),
        .expired_o (expired)
    );

`ifdef LIGHT_DRIVER_FAULT_EN
    logic fault_q, fault_d, fault_set;
    logic [3:0] owner_mask_q;

    assign owner_mask_q = 4'b0001 << owner_q;
    assign fault_set = ((phase_q == PH_ALL_RED) && multi_hot(allow)) ||
                       ((phase_q == PH_GREEN) && |(allow & ~owner_mask_q));
    assign fault_d      = fault_q | fault_set;
    assign block        = fault_d;
    assign force_yellow = fault_d;
    assign fault        = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign block        = 1'b0;
    assign force_yellow = 1'b0;
`endif

    always_comb begin
        phase_d    = phase_q;
        owner_d    = owner_q;
        timer_load = 1'b0;
        timer_val  = ALLRED_LOAD;
        case (phase_q)
            PH_ALL_RED: begin
                if (expired && (|allow) && !block) begin
                    phase_d    = PH_GREEN;
                    owner_d    = lowest_lane(allow);
                    timer_load = 1'b1;
                    timer_val  = '0;
                end
            end
            PH_GREEN: begin
                if (!allow[owner_q] || force_yellow) begin
                    phase_d    = PH_YELLOW;
                    timer_load = 1'b1;
                    timer_val  = YEL_LOAD;
                end
            end
            PH_YELLOW: begin
                // Re-asserted grants are ignored; yellow always runs to expiry.
                if (expired) begin
                    phase_d    = PH_ALL_RED;
                    owner_d    = '0;
                    timer_load = 1'b1;
                    timer_val  = ALLRED_LOAD;
                end
            end
            default: begin
                phase_d    = PH_ALL_RED;
                owner_d    = '0;
                timer_load = 1'b1;
                timer_val  = ALLRED_LOAD;
            end
        endcase
    end

    // Lamps are registered from the next state so they line up with phase/owner.
    always_comb begin
        owner_mask_d = 4'b0001 << owner_d;
        red_d        = 4'b1111;
        yel_d        = 4'b0000;
        grn_d        = 4'b0000;
        case (phase_d)
            PH_GREEN: begin
                red_d = ~owner_mask_d;
                grn_d = owner_mask_d;
            end
            PH_YELLOW: begin
                red_d = ~owner_mask_d;
                yel_d = owner_mask_d;
            end
            default: begin
                red_d = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_ALL_RED;
            owner_q <= '0;
            red_q   <= 4'b1111;
            yel_q   <= 4'b0000;
            grn_q   <= 4'b0000;
        end else begin
            phase_q <= phase_d;
            owner_q <= owner_d;
            red_q   <= red_d;
            yel_q   <= yel_d;
            grn_q   <= grn_d;
        end
    end

    assign lamp_red    = red_q;
    assign lamp_yellow = yel_q;
    assign lamp_green  = grn_q;
    assign phase       = phase_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_traffic_light_driver.sv
// Directed-vector bench for traffic_light_driver (YELLOW_CYCLES=3, ALLRED_CYCLES=2).
module tb_traffic_light_driver;

`ifdef LIGHT_DRIVER_FAULT_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    localparam int W = 17;

    logic       clk = 1'b0;
    logic       rst;
    logic       allow_0, allow_1, allow_2, allow_3;
    logic [3:0] lamp_red, lamp_yellow, lamp_green;
    logic [1:0] phase, owner;
    logic       dut_fault;
    logic       done = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    always #5 clk = ~clk;

    traffic_light_driver #(
        .YELLOW_CYCLES(3),
        .ALLRED_CYCLES(2),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .allow_0    (allow_0),
        .allow_1    (allow_1),
        .allow_2    (allow_2),
        .allow_3    (allow_3),
        .lamp_red   (lamp_red),
        .lamp_yellow(lamp_yellow),
        .lamp_green (lamp_green),
        .phase      (phase),
`ifdef LIGHT_DRIVER_FAULT_EN
        .owner      (owner),
        .fault      (dut_fault)
`else
        .owner      (owner)
`endif
    );

`ifndef LIGHT_DRIVER_FAULT_EN
    assign dut_fault = 1'b0;
`endif

    function automatic logic [W-1:0] ev(input logic [3:0] r, input logic [3:0] y,
                                        input logic [3:0] g, input logic [1:0] ph,
                                        input logic [1:0] own, input logic f);
        return {f, r, y, g, ph, own};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] a, input logic [W-1:0] e, input string tag);
        @(negedge clk);
        rst = r;
        {allow_3, allow_2, allow_1, allow_0} = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
    endtask

    // Monitor: every edge checks the lamp invariant and pops one expected vector.
    initial begin
        logic [W-1:0] e, act;
        string        tag;
        int           nonred;
        bit           lane_ok;
        forever begin
            @(posedge clk);
            #1;
            lane_ok = 1'b1;
            nonred  = 0;
            for (int i = 0; i < 4; i++) begin
                if ((int'(lamp_red[i]) + int'(lamp_yellow[i]) + int'(lamp_green[i])) != 1) lane_ok = 1'b0;
                if (lamp_red[i] !== 1'b1) nonred++;
            end
            checks++;
            if (!lane_ok) begin
                errors++;
                $display("FAIL one_lamp_per_lane: got r=%b y=%b g=%b required exactly one lit per lane",
                         lamp_red, lamp_yellow, lamp_green);
            end
            checks++;
            if (nonred > 1) begin
                errors++;
                $display("FAIL single_nonred_lane: got %0d non-red lanes required <=1", nonred);
            end
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                tag = tag_q.pop_front();
                act = {dut_fault, lamp_red, lamp_yellow, lamp_green, phase, owner};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got f=%b r=%b y=%b g=%b ph=%0d own=%0d required f=%b r=%b y=%b g=%b ph=%0d own=%0d",
                             tag, act[16], act[15:12], act[11:8], act[7:4], act[3:2], act[1:0],
                             e[16], e[15:12], e[11:8], e[7:4], e[3:2], e[1:0]);
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: got %0d unchecked vectors required 0", exp_q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ar0, arf, g2, y2, g0, y0, g1, y1;
        ar0 = ev(4'b1111, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);
        arf = ev(4'b1111, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b1);
        g2  = ev(4'b1011, 4'b0000, 4'b0100, 2'd1, 2'd2, 1'b0);
        y2  = ev(4'b1011, 4'b0100, 4'b0000, 2'd2, 2'd2, 1'b0);
        g0  = ev(4'b1110, 4'b0000, 4'b0001, 2'd1, 2'd0, 1'b0);
        y0  = ev(4'b1110, 4'b0001, 4'b0000, 2'd2, 2'd0, 1'b0);
        g1  = ev(4'b1101, 4'b0000, 4'b0010, 2'd1, 2'd1, 1'b0);
        y1  = ev(4'b1101, 4'b0010, 4'b0000, 2'd2, 2'd1, 1'b0);

        rst = 1'b1;
        {allow_3, allow_2, allow_1, allow_0} = 4'b0000;

        // Reset state
        step(1'b1, 4'b0000, ar0, "reset_a");
        step(1'b1, 4'b0000, ar0, "reset_b");

        // Release with lane 2 requesting: clearance first, then green
        step(1'b0, 4'b0100, ar0, "clear_after_reset");
        step(1'b0, 4'b0100, g2,  "green2");
        step(1'b0, 4'b0100, g2,  "hold_green2");

        // Drop lane 2: three yellow, two all-red, then lane 0 green
        step(1'b0, 4'b0000, y2,  "yellow2_1");
        step(1'b0, 4'b0000, y2,  "yellow2_2");
        step(1'b0, 4'b0000, y2,  "yellow2_3");
        step(1'b0, 4'b0000, ar0, "allred_1");
        step(1'b0, 4'b0001, ar0, "allred_2");
        step(1'b0, 4'b0001, g0,  "green0");
        step(1'b0, 4'b0001, g0,  "hold_green0");

        // Re-raising lane 0 during its yellow must not abort it
        step(1'b0, 4'b0000, y0,  "yellow0_1");
        step(1'b0, 4'b0001, y0,  "yellow0_reraise_2");
        step(1'b0, 4'b0001, y0,  "yellow0_reraise_3");
        step(1'b0, 4'b0001, ar0, "allred0_1");
        step(1'b0, 4'b0001, ar0, "allred0_2");
        step(1'b0, 4'b0001, g0,  "regreen0");

        // Back to an idle all-red with the clearance fully expired
        step(1'b0, 4'b0000, y0,  "yellow0b_1");
        step(1'b0, 4'b0000, y0,  "yellow0b_2");
        step(1'b0, 4'b0000, y0,  "yellow0b_3");
        step(1'b0, 4'b0000, ar0, "idle_allred_1");
        step(1'b0, 4'b0000, ar0, "idle_allred_2");
        step(1'b0, 4'b0000, ar0, "idle_allred_held");

        // Conflicting requests lanes 1 and 3
        step(1'b0, 4'b1010, FB ? arf : g1, "multi_grant");
        step(1'b0, 4'b1010, FB ? arf : g1, "ignore_lane3");
        step(1'b0, 4'b1000, FB ? arf : y1, "yellow1_1");
        step(1'b0, 4'b1000, FB ? arf : y1, "yellow1_2");

        // Reset mid-yellow, then the full clearance before green again
        step(1'b1, 4'b1000, ar0, "reset_mid_yellow");
        step(1'b0, 4'b0100, ar0, "clear_after_reset2");
        step(1'b0, 4'b0100, g2,  "green2_after_reset");

        @(negedge clk);
        done = 1'b1;
    end

endmodule
